// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
//
// Purpose : Bundles the request and result signals of shift_sequencer so a
//           requester and the sequencer can be connected with one port.
//
// Signals :
//   start    - request to begin an operation (requester -> sequencer)
//   a        - operand, LEN bits
//   amt      - shift distance, AW bits
//   dir      - 0 = logical left, 1 = logical right
//   busy     - operation in progress (sequencer -> requester)
//   done     - one-cycle completion pulse
//   response - shifted result, LEN bits
//   n,c,z,v  - negative / carry / zero / overflow flags of the last result
//
// Modports: master (requester side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int LEN = 4,
  parameter int AW  = 3
);

  logic           start;
  logic [LEN-1:0] a;
  logic [AW-1:0]  amt;
  logic           dir;

  logic           busy;
  logic           done;
  logic [LEN-1:0] response;
  logic           n;
  logic           c;
  logic           z;
  logic           v;

  modport master (
    output start, a, amt, dir,
    input  busy, done, response, n, c, z, v
  );

  modport slave (
    input  start, a, amt, dir,
    output busy, done, response, n, c, z, v
  );

endinterface

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose : Multi-cycle logical shifter. An accepted request is shifted one
//           bit per clock; after the last step the result and its flags are
//           published with a one-cycle done pulse.
//
// Ports   :
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - shift_sequencer_if.slave (start/a/amt/dir in,
//          busy/done/response/n/c/z/v out)
//
// Timing  : with effective amount N = min(amt, LEN), the accepting edge is
//           followed by N shift edges and one completion edge, so done is
//           high in the cycle after edge N+1 and busy is high for N+1 cycles.
//
// Requires LEN >= 2 and 2^AW - 1 >= LEN.
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int LEN = 4,
  parameter int AW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  shift_sequencer_if.slave bus
);

  // Counter must hold values 0..LEN inclusive.
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [LEN-1:0]  work_reg;
  logic [CW-1:0]   cnt_reg;
  logic            dir_reg;
  logic            carry_reg;   // bit shifted out by the most recent step
  logic            ovf_reg;     // sticky: MSB changed during a left shift

  logic            busy_reg;
  logic            done_reg;
  logic [LEN-1:0]  response_reg;
  logic            n_reg;
  logic            c_reg;
  logic            z_reg;
  logic            v_reg;

  logic [LEN-1:0]  shl_next;
  logic [LEN-1:0]  shr_next;
  logic [CW-1:0]   amt_eff;

  // ---------------------------------------------------------------------------
  // Single-bit shift networks of the working register, zero filled.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shl_next[gi] = 1'b0;
      end else begin : g_shl
        assign shl_next[gi] = work_reg[gi-1];
      end

      if (gi == LEN - 1) begin : g_msb
        assign shr_next[gi] = 1'b0;
      end else begin : g_shr
        assign shr_next[gi] = work_reg[gi+1];
      end
    end
  endgenerate

  // Distances beyond the operand width behave like a full-width shift,
  // which clears the result; clamping also bounds the latency.
  always_comb begin
    amt_eff = CW'(bus.amt);
    if (bus.amt > AW'(LEN)) begin
      amt_eff = CW'(LEN);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs are registers updated here so they are glitch
  // free and hold steady while an operation is in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      work_reg     <= '0;
      cnt_reg      <= '0;
      dir_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      response_reg <= '0;
      n_reg        <= 1'b0;
      c_reg        <= 1'b0;
      z_reg        <= 1'b0;
      v_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      case (state_reg)
        // DONE behaves like IDLE for acceptance, which allows a new request
        // to follow a completion with no idle cycle in between.
        IDLE, DONE: begin
          if (bus.start) begin
            work_reg  <= bus.a;
            dir_reg   <= bus.dir;
            cnt_reg   <= amt_eff;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end

        // start is deliberately not looked at here: the captured operands
        // stay untouched until the operation completes.
        SHIFT: begin
          if (cnt_reg != '0) begin
            if (dir_reg) begin
              work_reg  <= shr_next;
              carry_reg <= work_reg[0];
            end else begin
              work_reg  <= shl_next;
              carry_reg <= work_reg[LEN-1];
              // The new MSB is the current bit below it; any difference
              // means this step changed the sign bit.
              if (work_reg[LEN-1] != work_reg[LEN-2]) begin
                ovf_reg <= 1'b1;
              end
            end
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            response_reg <= work_reg;
            n_reg        <= work_reg[LEN-1];
            z_reg        <= (work_reg == '0);
            c_reg        <= carry_reg;
            v_reg        <= ovf_reg;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.response = response_reg;
  assign bus.n        = n_reg;
  assign bus.c        = c_reg;
  assign bus.z        = z_reg;
  assign bus.v        = v_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Drives shift_sequencer through its interface with directed and random
// requests and compares every observed cycle against a reference model that
// computes the result and flags directly from the shift rules.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int LEN = 4;
  localparam int AW  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_sequencer_if #(.LEN(LEN), .AW(AW)) bus ();

  shift_sequencer #(.LEN(LEN), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Last published result; outputs must hold these while busy.
  logic [LEN-1:0] prev_resp;
  logic [3:0]     prev_nczv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word shift, carry is the last bit to leave the word,
  // overflow is set when the sequence of MSB values seen over the steps is
  // not constant.
  function automatic void model(input logic [LEN-1:0] a, input int amt, input bit dir,
                                output logic [LEN-1:0] r, output bit c, output bit v);
    int  nn;
    bit  mk;
    nn = (amt > LEN) ? LEN : amt;
    r  = dir ? (a >> nn) : (a << nn);
    c  = 1'b0;
    v  = 1'b0;
    if (nn > 0) c = dir ? a[nn-1] : a[LEN-nn];
    if (!dir) begin
      for (int k = 1; k <= nn; k++) begin
        mk = (LEN - 1 - k >= 0) ? a[LEN-1-k] : 1'b0;
        if (mk != a[LEN-1]) v = 1'b1;
      end
    end
  endfunction

  // Called at a falling edge. Presents a request, lets it be accepted, then
  // checks busy/done/held outputs on every cycle up to completion. Returns
  // at the falling edge where done is expected high, with start low.
  // poke keeps start high (with fresh random operands) across the first
  // SHIFT edge, which must be ignored.
  task automatic run_op(input logic [LEN-1:0] a, input int amt, input bit dir,
                        input bit poke, input string tag);
    int             nn;
    logic [LEN-1:0] er;
    bit             ec, ev;
    logic [3:0]     enczv;
    model(a, amt, dir, er, ec, ev);
    nn    = (amt > LEN) ? LEN : amt;
    enczv = {er[LEN-1], ec, (er == '0), ev};

    bus.start = 1'b1;
    bus.a     = a;
    bus.amt   = AW'(amt);
    bus.dir   = dir;
    @(posedge clk);
    @(negedge clk);
    if (poke) begin
      bus.a   = LEN'($urandom);
      bus.amt = AW'($urandom);
      bus.dir = 1'($urandom);
    end else begin
      bus.start = 1'b0;
    end

    for (int e = 0; e <= nn + 1; e++) begin
      if (e > 0) @(negedge clk);
      if (e == 1) bus.start = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'(e <= nn));
      check({tag, "_done"}, 32'(bus.done), 32'(e == nn + 1));
      if (e <= nn) begin
        check({tag, "_hold_resp"}, 32'(bus.response), 32'(prev_resp));
        check({tag, "_hold_flags"}, 32'({bus.n, bus.c, bus.z, bus.v}), 32'(prev_nczv));
      end else begin
        check({tag, "_resp"}, 32'(bus.response), 32'(er));
        check({tag, "_nczv"}, 32'({bus.n, bus.c, bus.z, bus.v}), 32'(enczv));
        prev_resp = er;
        prev_nczv = enczv;
      end
    end
    $display("%s: a=%b amt=%0d dir=%0d poke=%0d -> resp=%b nczv=%b (exp %b %b)",
             tag, a, amt, dir, poke, bus.response, {bus.n, bus.c, bus.z, bus.v}, er, enczv);
  endtask

  task automatic idle(input int k);
    bus.start = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_resp", 32'(bus.response), 32'(prev_resp));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_resp"}, 32'(bus.response), 32'd0);
    check({tag, "_nczv"}, 32'({bus.n, bus.c, bus.z, bus.v}), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.amt   = '0;
    bus.dir   = 1'b0;
    prev_resp = '0;
    prev_nczv = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // First start presented together with reset release.
    rst = 1'b0;
    run_op(4'b1111, 2, 1'b0, 1'b0, "left_1111_2");
    check("left_1111_2_const", 32'({bus.response, bus.n, bus.c, bus.z, bus.v}), 32'(8'b1100_1100));
    idle(2);

    run_op(4'b0111, 1, 1'b0, 1'b0, "left_0111_1");
    check("left_0111_1_const", 32'({bus.response, bus.n, bus.c, bus.z, bus.v}), 32'(8'b1110_1001));

    // Back-to-back from DONE.
    run_op(4'b0001, 2, 1'b1, 1'b0, "right_0001_2");
    check("right_0001_2_const", 32'({bus.response, bus.n, bus.c, bus.z, bus.v}), 32'(8'b0000_0010));
    idle(1);

    run_op(4'b1011, 7, 1'b0, 1'b0, "clamp_1011_7");
    check("clamp_1011_7_rcz", 32'({bus.response, bus.c, bus.z}), 32'(6'b0000_11));
    run_op(4'b1011, 0, 1'b0, 1'b0, "zero_1011_0");
    check("zero_1011_0_const", 32'({bus.response, bus.n, bus.c, bus.v}), 32'(7'b1011_100));

    // start held into a SHIFT edge with different operands: ignored.
    run_op(4'b0110, 3, 1'b1, 1'b1, "poke_0110_3");
    idle(1);

    // Reset in the middle of an operation.
    bus.start = 1'b1;
    bus.a     = 4'b1111;
    bus.amt   = AW'(4);
    bus.dir   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("abort");
    prev_resp = '0;
    prev_nczv = '0;
    idle(8);
    run_op(4'b1001, 1, 1'b1, 1'b0, "after_abort");
    idle(1);

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      run_op(LEN'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
